prog_loader: RTL and testbench

//  Writer side of the program-memory interface. Receives a framed byte stream from an external host
//  and assembles it into 16-bit instruction words, which it writes into program memory at

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader.sv | 180 ++++++++++++++++++
 tb/tb_prog_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program memory loader
package prog_loader_pkg;

    localparam int          LOADER_DATA_W = 16;
    localparam int          LOADER_ADDR_W = 8;
    localparam logic [7:0]  LOADER_SYNC   = 8'hA5;

    typedef enum logic [3:0] {
        LD_IDLE,
        LD_SYNC,
        LD_LEN,
        LD_HI,
        LD_LO,
        LD_WRITE,
        LD_CSUM,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

    // Running frame checksum is a plain XOR over every payload byte.
    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to program memory writer with CPU hold
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         DATA_W    = LOADER_DATA_W,
    parameter int         ADDR_W    = LOADER_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = LOADER_SYNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int             REM_W    = ADDR_W + 1;
    // A length byte of zero encodes a full 256-word image.
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(256);

    loader_state_t     state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [7:0]        csum_q, csum_d;
    logic [REM_W-1:0]  wl_q, wl_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_wdata_q, last_wdata_d;

    logic [DATA_W-1:0] word;

    assign word = DATA_W'({hi_q, lo_q});

    // State register; an asynchronous reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: assembled bytes, address, counters, flags and held write port values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q         <= '0;
            lo_q         <= '0;
            addr_q       <= '0;
            rem_q        <= '0;
            csum_q       <= '0;
            wl_q         <= '0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            csum_q       <= csum_d;
            wl_q         <= wl_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    // Next-state, datapath updates and stream/memory handshake outputs.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        csum_d       = csum_q;
        wl_d         = wl_q;
        hold_d       = hold_q;
        done_d       = done_q;
        err_d        = err_q;
        last_addr_d  = last_addr_q;
        last_wdata_d = last_wdata_q;
        in_ready     = 1'b0;
        pm_we        = 1'b0;
        pm_addr      = last_addr_q;
        pm_wdata     = last_wdata_q;

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                // Arming clears the previous frame's status but not the write port hold values.
                if (start) begin
                    state_d = LD_SYNC;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    wl_d    = '0;
                    csum_d  = '0;
                    hold_d  = 1'b1;
                end
            end
            LD_SYNC: begin
                in_ready = 1'b1;
                if (in_valid && (in_byte == SYNC_BYTE)) begin
                    state_d = LD_LEN;
                end
            end
            LD_LEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rem_d   = (in_byte == 8'd0) ? REM_FULL : REM_W'(in_byte);
                    state_d = LD_HI;
                end
            end
            LD_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hi_d    = in_byte;
                    csum_d  = csum_next(csum_q, in_byte);
                    state_d = LD_LO;
                end
            end
            LD_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lo_d    = in_byte;
                    csum_d  = csum_next(csum_q, in_byte);
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                // Stream is stalled for this cycle while the assembled word goes to memory.
                pm_we        = 1'b1;
                pm_addr      = addr_q;
                pm_wdata     = word;
                last_addr_d  = addr_q;
                last_wdata_d = word;
                addr_d       = addr_q + ADDR_W'(1);
                wl_d         = wl_q + REM_W'(1);
                rem_d        = rem_q - REM_W'(1);
                state_d      = (rem_q == REM_W'(1)) ? LD_CSUM : LD_HI;
            end
            LD_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d = 1'b0;
                    if (in_byte == csum_q) begin
                        done_d  = 1'b1;
                        state_d = LD_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = LD_ERROR;
                    end
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        pm_we;
    logic [7:0]  pm_addr;
    logic [15:0] pm_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pm_we        (pm_we),
        .pm_addr      (pm_addr),
        .pm_wdata     (pm_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic        done;
        logic        err;
        logic [8:0]  wl;
        logic [7:0]  last_addr;
        logic [15:0] last_data;
    } st_t;

    wr_t         wq[$];
    st_t         sq[$];
    logic [15:0] frame_words[$];
    logic [7:0]  garbage_q[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        int t;
        repeat (int'($urandom_range(0, gap))) @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        if (noise && ($urandom_range(0, 3) == 0)) start = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            start = 1'b0;
            t++;
        end
        chk("handshake", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Model: expected writes and status follow directly from the frame contents.
    task automatic send_frame(input logic [7:0] len_b, input bit bad, input int gap,
                              input bit noise, input bit push_status, input int words_to_send);
        logic [7:0] csum;
        logic [7:0] ebyte;
        st_t        s;
        int         n;
        n    = frame_words.size();
        csum = 8'd0;
        for (int i = 0; i < n; i++) begin
            csum = csum ^ frame_words[i][15:8] ^ frame_words[i][7:0];
        end
        for (int i = 0; i < words_to_send; i++) begin
            wq.push_back('{addr: 8'(i), data: frame_words[i]});
        end
        if (push_status) begin
            s.done      = !bad;
            s.err       = bad;
            s.wl        = 9'(n);
            s.last_addr = 8'(n - 1);
            s.last_data = frame_words[n-1];
            sq.push_back(s);
        end
        do_start();
        foreach (garbage_q[i]) send_byte(garbage_q[i], gap, noise);
        send_byte(8'hA5, gap, noise);
        send_byte(len_b, gap, noise);
        for (int i = 0; i < words_to_send; i++) begin
            send_byte(frame_words[i][15:8], gap, noise);
            send_byte(frame_words[i][7:0], gap, noise);
        end
        if (words_to_send == n) begin
            ebyte = bad ? (csum ^ 8'h01) : csum;
            send_byte(ebyte, gap, 1'b0);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic load_t1_frame();
        frame_words.delete();
        frame_words.push_back(16'h1234);
        frame_words.push_back(16'hABCD);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, " pm_we"}, {31'd0, pm_we}, 32'd0);
        chk({tag, " pm_addr"}, {24'd0, pm_addr}, 32'd0);
        chk({tag, " pm_wdata"}, {16'd0, pm_wdata}, 32'd0);
        chk({tag, " cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " error"}, {31'd0, error}, 32'd0);
        chk({tag, " words_loaded"}, {23'd0, words_loaded}, 32'd0);
    endtask

    // Monitor: pops expected writes on pm_we and expected status when cpu_hold falls.
    initial begin : monitor
        logic prev_hold;
        wr_t  w;
        st_t  s;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (pm_we) begin
                    chk("in_ready during write", {31'd0, in_ready}, 32'd0);
                    if (wq.size() == 0) begin
                        chk("unexpected write", 32'd1, 32'd0);
                    end else begin
                        w = wq.pop_front();
                        chk("pm_addr", {24'd0, pm_addr}, {24'd0, w.addr});
                        chk("pm_wdata", {16'd0, pm_wdata}, {16'd0, w.data});
                    end
                end
                if (prev_hold && !cpu_hold) begin
                    if (sq.size() == 0) begin
                        chk("unexpected frame end", 32'd1, 32'd0);
                    end else begin
                        s = sq.pop_front();
                        chk("done", {31'd0, done}, {31'd0, s.done});
                        chk("error", {31'd0, error}, {31'd0, s.err});
                        chk("words_loaded", {23'd0, words_loaded}, {23'd0, s.wl});
                        chk("held pm_addr", {24'd0, pm_addr}, {24'd0, s.last_addr});
                        chk("held pm_wdata", {16'd0, pm_wdata}, {16'd0, s.last_data});
                        chk("pm_we after frame", {31'd0, pm_we}, 32'd0);
                    end
                end
            end
            prev_hold = cpu_hold;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int len;
        rst      = 1'b1;
        start    = 1'b0;
        in_byte  = 8'd0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic two-word frame, good checksum.
        load_t1_frame();
        send_frame(8'h02, 1'b0, 0, 1'b0, 1'b1, 2);

        // Same frame, checksum off by one bit.
        load_t1_frame();
        send_frame(8'h02, 1'b1, 0, 1'b0, 1'b1, 2);

        // Garbage ahead of the sync byte.
        load_t1_frame();
        garbage_q.push_back(8'h00);
        garbage_q.push_back(8'hFF);
        garbage_q.push_back(8'h5A);
        send_frame(8'h02, 1'b0, 1, 1'b0, 1'b1, 2);
        garbage_q.delete();

        // Full 256-word image, data equals address.
        frame_words.delete();
        for (int i = 0; i < 256; i++) frame_words.push_back(16'(i));
        send_frame(8'h00, 1'b0, 0, 1'b0, 1'b1, 256);

        // Random frames with stream gaps and stray start pulses.
        for (int f = 0; f < 6; f++) begin
            len = int'($urandom_range(1, 20));
            frame_words.delete();
            for (int i = 0; i < len; i++) frame_words.push_back(16'($urandom()));
            send_frame(8'(len), ($urandom_range(0, 2) == 0), 3, 1'b1, 1'b1, len);
        end

        // Reset after the second word of a four-word frame.
        frame_words.delete();
        for (int i = 0; i < 4; i++) frame_words.push_back(16'h1000 + 16'(i));
        send_frame(8'h04, 1'b0, 0, 1'b0, 1'b0, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid-frame reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        load_t1_frame();
        send_frame(8'h02, 1'b0, 0, 1'b0, 1'b1, 2);

        repeat (5) @(negedge clk);
        chk("pending writes", wq.size(), 32'd0);
        chk("pending frames", sq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
